// File: rtl/ysyx_24090013_regfile.sv
// RV32 general-purpose register file with a one-entry writeback register between EX and the array.
// Reads bypass the pending writeback so ID never sees stale data; x0 is hardwired to zero.
module ysyx_24090013_regfile #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_reg_rd_wen,
  input  logic [ADDR_W-1:0] ex_reg_rd_addr,
  input  logic [DATA_W-1:0] ex_reg_rd_data,
  input  logic [ADDR_W-1:0] id_reg_rs1_addr,
  input  logic [ADDR_W-1:0] id_reg_rs2_addr,
  output logic [DATA_W-1:0] reg_id_rs1_data,
  output logic [DATA_W-1:0] reg_id_rs2_data,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic              wb_pending,
  output logic [31:0]       wr_count
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] gpr_q [DEPTH];
  logic [DATA_W-1:0] gpr_d [DEPTH];
  logic              wb_valid_q, wb_valid_d;
  logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic [31:0]       wr_count_q, wr_count_d;

  // Read mux shared by every port; the ex_reg_* inputs are deliberately absent to keep ID->EX->ID acyclic.
  function automatic logic [DATA_W-1:0] read_mux(
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] array_val,
    input logic              wb_valid,
    input logic [ADDR_W-1:0] wb_addr,
    input logic [DATA_W-1:0] wb_data
  );
    logic [DATA_W-1:0] result;
    if (addr == {ADDR_W{1'b0}}) begin
      result = {DATA_W{1'b0}};
    end else if (wb_valid && (wb_addr == addr)) begin
      result = wb_data;
    end else begin
      result = array_val;
    end
    return result;
  endfunction

  // Capture the EX write into the WB register and commit the previously captured one to the array.
  always_comb begin
    wb_valid_d = ex_reg_rd_wen && (ex_reg_rd_addr != {ADDR_W{1'b0}});
    wb_addr_d  = ex_reg_rd_addr;
    wb_data_d  = ex_reg_rd_data;
    gpr_d      = gpr_q;
    wr_count_d = wr_count_q;
    if (wb_valid_q) begin
      gpr_d[wb_addr_q] = wb_data_q;
      wr_count_d       = wr_count_q + 32'd1;
    end else begin
      wr_count_d = wr_count_q;
    end
    gpr_d[0] = {DATA_W{1'b0}};
  end

  // State registers; reset clears the array and drops any pending write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        gpr_q[i] <= {DATA_W{1'b0}};
      end
      wb_valid_q <= 1'b0;
      wb_addr_q  <= {ADDR_W{1'b0}};
      wb_data_q  <= {DATA_W{1'b0}};
      wr_count_q <= 32'd0;
    end else begin
      gpr_q      <= gpr_d;
      wb_valid_q <= wb_valid_d;
      wb_addr_q  <= wb_addr_d;
      wb_data_q  <= wb_data_d;
      wr_count_q <= wr_count_d;
    end
  end

  assign reg_id_rs1_data = read_mux(id_reg_rs1_addr, gpr_q[id_reg_rs1_addr],
                                    wb_valid_q, wb_addr_q, wb_data_q);
  assign reg_id_rs2_data = read_mux(id_reg_rs2_addr, gpr_q[id_reg_rs2_addr],
                                    wb_valid_q, wb_addr_q, wb_data_q);
  assign dbg_data        = read_mux(dbg_addr, gpr_q[dbg_addr],
                                    wb_valid_q, wb_addr_q, wb_data_q);
  assign wb_pending      = wb_valid_q;
  assign wr_count        = wr_count_q;

endmodule

// File: tb/tb_ysyx_24090013_regfile.sv
// Directed bench for ysyx_24090013_regfile: stimulus queues expected values per cycle,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_ysyx_24090013_regfile;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_reg_rd_wen = 1'b0;
  logic [4:0]  ex_reg_rd_addr = 5'd0;
  logic [31:0] ex_reg_rd_data = 32'd0;
  logic [4:0]  id_reg_rs1_addr = 5'd0;
  logic [4:0]  id_reg_rs2_addr = 5'd0;
  logic [31:0] reg_id_rs1_data;
  logic [31:0] reg_id_rs2_data;
  logic [4:0]  dbg_addr = 5'd0;
  logic [31:0] dbg_data;
  logic        wb_pending;
  logic [31:0] wr_count;

  ysyx_24090013_regfile dut (
    .clk             (clk),
    .rst             (rst),
    .ex_reg_rd_wen   (ex_reg_rd_wen),
    .ex_reg_rd_addr  (ex_reg_rd_addr),
    .ex_reg_rd_data  (ex_reg_rd_data),
    .id_reg_rs1_addr (id_reg_rs1_addr),
    .id_reg_rs2_addr (id_reg_rs2_addr),
    .reg_id_rs1_data (reg_id_rs1_data),
    .reg_id_rs2_data (reg_id_rs2_data),
    .dbg_addr        (dbg_addr),
    .dbg_data        (dbg_data),
    .wb_pending      (wb_pending),
    .wr_count        (wr_count)
  );

  always #5 clk = ~clk;

  localparam int K_RS1 = 0;
  localparam int K_RS2 = 1;
  localparam int K_DBG = 2;
  localparam int K_PND = 3;
  localparam int K_CNT = 4;

  typedef struct {
    int          cyc;
    int          tag;
    int          kind;
    logic [31:0] exp;
  } sb_t;

  sb_t sb_q[$];
  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every entry scheduled for the current cycle.
  always @(negedge clk) begin
    sb_t         ent;
    logic [31:0] act;
    string       kname;
    while (sb_q.size() != 0 && sb_q[0].cyc <= cyc) begin
      ent = sb_q.pop_front();
      case (ent.kind)
        K_RS1:   begin act = reg_id_rs1_data;        kname = "rs1"; end
        K_RS2:   begin act = reg_id_rs2_data;        kname = "rs2"; end
        K_DBG:   begin act = dbg_data;               kname = "dbg"; end
        K_PND:   begin act = {31'd0, wb_pending};    kname = "pending"; end
        K_CNT:   begin act = wr_count;               kname = "wr_count"; end
        default: begin act = 32'hxxxx_xxxx;          kname = "unknown"; end
      endcase
      checks++;
      if (act !== ent.exp) begin
        errors++;
        $display("FAIL test%0d_%s cyc %0d got %h want %h", ent.tag, kname, cyc, act, ent.exp);
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic wen, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] ad);
    ex_reg_rd_wen   = wen;
    ex_reg_rd_addr  = wa;
    ex_reg_rd_data  = wd;
    id_reg_rs1_addr = a1;
    id_reg_rs2_addr = a2;
    dbg_addr        = ad;
  endtask

  task automatic expect_v(input int tag, input int kind, input logic [31:0] v);
    sb_t e;
    e.cyc  = cyc;
    e.tag  = tag;
    e.kind = kind;
    e.exp  = v;
    sb_q.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    next_cycle();
    next_cycle();
    // Reset release: everything reads zero
    next_cycle();
    rst = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 5'd5, 5'd7, 5'd31);
    expect_v(0, K_RS1, 32'd0);
    expect_v(0, K_RS2, 32'd0);
    expect_v(0, K_DBG, 32'd0);
    expect_v(0, K_PND, 32'd0);
    expect_v(0, K_CNT, 32'd0);

    // Write x5 = DEADBEEF; latency and wen=0 with nonzero addr/data
    next_cycle();
    drive(1'b1, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd0, 5'd0);
    expect_v(2, K_RS1, 32'd0);
    expect_v(2, K_PND, 32'd0);
    next_cycle();
    drive(1'b0, 5'd5, 32'h5555_AAAA, 5'd5, 5'd0, 5'd0);
    expect_v(2, K_RS1, 32'hDEAD_BEEF);
    expect_v(2, K_PND, 32'd1);
    expect_v(2, K_CNT, 32'd0);
    next_cycle();
    drive(1'b0, 5'd5, 32'h5555_AAAA, 5'd5, 5'd0, 5'd5);
    expect_v(2, K_RS1, 32'hDEAD_BEEF);
    expect_v(2, K_PND, 32'd0);
    expect_v(2, K_CNT, 32'd1);
    next_cycle();
    drive(1'b0, 5'd0, 32'd0, 5'd5, 5'd0, 5'd5);
    expect_v(2, K_RS1, 32'hDEAD_BEEF);
    expect_v(2, K_DBG, 32'hDEAD_BEEF);
    expect_v(2, K_CNT, 32'd1);

    // Write to x0 is dropped
    next_cycle();
    drive(1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd0);
    expect_v(3, K_RS1, 32'd0);
    expect_v(3, K_PND, 32'd0);
    next_cycle();
    drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 5'd0);
    expect_v(3, K_RS1, 32'd0);
    expect_v(3, K_DBG, 32'd0);
    expect_v(3, K_PND, 32'd0);
    expect_v(3, K_CNT, 32'd1);
    next_cycle();
    expect_v(3, K_RS1, 32'd0);
    expect_v(3, K_PND, 32'd0);
    expect_v(3, K_CNT, 32'd1);

    // Back-to-back writes to x7
    next_cycle();
    drive(1'b1, 5'd7, 32'd1, 5'd0, 5'd7, 5'd0);
    expect_v(4, K_RS2, 32'd0);
    next_cycle();
    drive(1'b1, 5'd7, 32'd2, 5'd0, 5'd7, 5'd0);
    expect_v(4, K_RS2, 32'd1);
    expect_v(4, K_PND, 32'd1);
    expect_v(4, K_CNT, 32'd1);
    next_cycle();
    drive(1'b0, 5'd7, 32'd0, 5'd0, 5'd7, 5'd0);
    expect_v(4, K_RS2, 32'd2);
    expect_v(4, K_PND, 32'd1);
    expect_v(4, K_CNT, 32'd2);
    next_cycle();
    drive(1'b0, 5'd0, 32'd0, 5'd7, 5'd7, 5'd7);
    expect_v(4, K_RS1, 32'd2);
    expect_v(4, K_RS2, 32'd2);
    expect_v(4, K_DBG, 32'd2);
    expect_v(4, K_PND, 32'd0);
    expect_v(4, K_CNT, 32'd3);

    // x31 visible on all three ports; others untouched
    next_cycle();
    drive(1'b1, 5'd31, 32'h0000_1234, 5'd31, 5'd31, 5'd31);
    expect_v(5, K_RS1, 32'd0);
    expect_v(5, K_DBG, 32'd0);
    next_cycle();
    drive(1'b0, 5'd0, 32'd0, 5'd31, 5'd31, 5'd31);
    expect_v(5, K_RS1, 32'h0000_1234);
    expect_v(5, K_RS2, 32'h0000_1234);
    expect_v(5, K_DBG, 32'h0000_1234);
    next_cycle();
    drive(1'b0, 5'd0, 32'd0, 5'd5, 5'd7, 5'd31);
    expect_v(5, K_RS1, 32'hDEAD_BEEF);
    expect_v(5, K_RS2, 32'd2);
    expect_v(5, K_DBG, 32'h0000_1234);
    expect_v(5, K_CNT, 32'd4);

    // Async reset with a write pending
    next_cycle();
    drive(1'b1, 5'd9, 32'hCAFE_F00D, 5'd9, 5'd5, 5'd31);
    expect_v(1, K_RS1, 32'd0);
    next_cycle();
    drive(1'b1, 5'd9, 32'h0BAD_C0DE, 5'd9, 5'd5, 5'd9);
    expect_v(1, K_RS1, 32'hCAFE_F00D);
    expect_v(1, K_DBG, 32'hCAFE_F00D);
    expect_v(1, K_PND, 32'd1);
    expect_v(1, K_CNT, 32'd4);
    next_cycle();
    drive(1'b0, 5'd0, 32'd0, 5'd9, 5'd5, 5'd31);
    #1;
    rst = 1'b1;
    expect_v(1, K_RS1, 32'd0);
    expect_v(1, K_RS2, 32'd0);
    expect_v(1, K_DBG, 32'd0);
    expect_v(1, K_PND, 32'd0);
    expect_v(1, K_CNT, 32'd0);
    next_cycle();
    rst = 1'b0;
    expect_v(1, K_RS1, 32'd0);
    expect_v(1, K_PND, 32'd0);
    next_cycle();
    expect_v(1, K_RS1, 32'd0);
    expect_v(1, K_RS2, 32'd0);
    expect_v(1, K_DBG, 32'd0);
    expect_v(1, K_PND, 32'd0);
    expect_v(1, K_CNT, 32'd0);

    // Counter wrap
    next_cycle();
    force dut.wr_count_q = 32'hFFFF_FFFF;
    drive(1'b1, 5'd3, 32'h0000_00A5, 5'd3, 5'd0, 5'd0);
    expect_v(6, K_CNT, 32'hFFFF_FFFF);
    expect_v(6, K_RS1, 32'd0);
    #6;
    release dut.wr_count_q;
    next_cycle();
    drive(1'b0, 5'd0, 32'd0, 5'd3, 5'd0, 5'd0);
    expect_v(6, K_CNT, 32'hFFFF_FFFF);
    expect_v(6, K_PND, 32'd1);
    expect_v(6, K_RS1, 32'h0000_00A5);
    next_cycle();
    expect_v(6, K_CNT, 32'd0);
    expect_v(6, K_PND, 32'd0);
    expect_v(6, K_RS1, 32'h0000_00A5);

    next_cycle();
    next_cycle();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d entries left want 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
